burst_sequencer_ctrl: RTL and testbench



---
 rtl/burst_sequencer_ctrl.sv | 141 ++++++++++++++
 tb/tb_burst_sequencer_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/burst_sequencer_ctrl.sv
// Burst sequencer controller: takes one burst command at a time and issues
// per-beat address/last requests over a valid/ready handshake. A host
// configuration write controls enable, abort and sticky-flag clearing, and
// a status word reports progress, flags and the completed-burst count.
module burst_sequencer_ctrl #(
   parameter int DATA_WIDTH       = 32,
   parameter int ADDR_WIDTH       = 16,
   parameter int MAX_BURST_LENGTH = 256,
   localparam int LEN_W           = $clog2(MAX_BURST_LENGTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [LEN_W-1:0]      cmd_len,
   input  logic                  cmd_write,
   output logic                  beat_valid,
   input  logic                  beat_ready,
   output logic [ADDR_WIDTH-1:0] beat_addr,
   output logic                  beat_write,
   output logic                  beat_last,
   input  logic                  cfg_we,
   input  logic [DATA_WIDTH-1:0] cfg_wdata,
   output logic [DATA_WIDTH-1:0] status,
   output logic                  done,
   output logic                  error
);

   localparam int CNT_W = 16;

   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

   state_t               state, state_nxt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [LEN_W-1:0]      rem_q;
   logic                  write_q;
   logic                  enable_q;
   logic                  err_sticky_q;
   logic                  abt_sticky_q;
   logic                  err_pulse_q;
   logic [CNT_W-1:0]      burst_cnt_q;

   logic cmd_fire;
   logic beat_fire;
   logic abort_req;
   logic abort_fire;
   logic clr_sticky;
   logic len_ok;
   logic unused_cfg_bits;

   // A command length is legal only within 1..MAX_BURST_LENGTH.
   function automatic logic len_legal(input logic [LEN_W-1:0] len);
      return (len != '0) && (len <= LEN_W'(MAX_BURST_LENGTH));
   endfunction

   assign len_ok          = len_legal(cmd_len);
   assign abort_req       = cfg_we & cfg_wdata[1];
   assign clr_sticky      = cfg_we & cfg_wdata[2];
   assign cmd_fire        = cmd_valid & cmd_ready;
   assign beat_fire       = beat_valid & beat_ready;
   assign abort_fire      = abort_req & (state == ISSUE);
   assign unused_cfg_bits = ^cfg_wdata[DATA_WIDTH-1:3];

   assign beat_addr  = addr_q;
   assign beat_write = write_q;
   assign error      = err_pulse_q;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode and handshake outputs; abort wins over a same-cycle last beat.
   always_comb begin
      state_nxt  = state;
      cmd_ready  = 1'b0;
      beat_valid = 1'b0;
      beat_last  = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            cmd_ready = enable_q;
            if (cmd_valid && enable_q && len_ok) state_nxt = ISSUE;
         end
         ISSUE: begin
            beat_valid = 1'b1;
            beat_last  = (rem_q == LEN_W'(1));
            if (abort_req)                    state_nxt = IDLE;
            else if (beat_ready && beat_last) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Burst datapath, configuration, sticky flags and completion counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q       <= '0;
         rem_q        <= '0;
         write_q      <= 1'b0;
         enable_q     <= 1'b0;
         err_sticky_q <= 1'b0;
         abt_sticky_q <= 1'b0;
         err_pulse_q  <= 1'b0;
         burst_cnt_q  <= '0;
      end else begin
         err_pulse_q <= cmd_fire & ~len_ok;
         if (cfg_we) enable_q <= cfg_wdata[0];
         if (cmd_fire && len_ok) begin
            addr_q  <= cmd_addr;
            rem_q   <= cmd_len;
            write_q <= cmd_write;
         end else if (beat_fire) begin
            addr_q <= addr_q + ADDR_WIDTH'(1);
            rem_q  <= rem_q - LEN_W'(1);
         end
         if (abort_fire) rem_q <= '0;
         err_sticky_q <= (cmd_fire & ~len_ok) | (err_sticky_q & ~clr_sticky);
         abt_sticky_q <= abort_fire | (abt_sticky_q & ~clr_sticky);
         if (state == DONE) burst_cnt_q <= burst_cnt_q + CNT_W'(1);
      end
   end

   // Status word assembly; remaining reads zero whenever the sequencer is idle.
   always_comb begin
      status                = '0;
      status[LEN_W-1:0]     = (state == IDLE) ? '0 : rem_q;
      status[9]             = (state != IDLE);
      status[10]            = err_sticky_q;
      status[11]            = abt_sticky_q;
      status[12]            = enable_q;
      status[31:16]         = burst_cnt_q;
   end

endmodule

// File: tb/tb_burst_sequencer_ctrl.sv
// Randomized bench for burst_sequencer_ctrl, checked against a queue-based
// reference model of the expected beat stream, flags and counter.
module tb_burst_sequencer_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [15:0] cmd_addr;
   logic [8:0]  cmd_len;
   logic        cmd_write;
   logic        beat_valid;
   logic        beat_ready;
   logic [15:0] beat_addr;
   logic        beat_write;
   logic        beat_last;
   logic        cfg_we;
   logic [31:0] cfg_wdata;
   logic [31:0] status;
   logic        done;
   logic        error;

   int n_checks = 0;
   int n_errors = 0;

   // reference model: outstanding beat addresses plus flags
   logic [15:0] m_beats[$];
   bit          m_done, m_errp, m_en, m_err, m_abt, m_wr;
   logic [15:0] m_cnt;

   burst_sequencer_ctrl dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_len(cmd_len), .cmd_write(cmd_write),
      .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_addr(beat_addr),
      .beat_write(beat_write), .beat_last(beat_last),
      .cfg_we(cfg_we), .cfg_wdata(cfg_wdata), .status(status),
      .done(done), .error(error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit m_idle();
      return (m_beats.size() == 0) && !m_done;
   endfunction

   function automatic logic [31:0] m_status();
      return {m_cnt, 3'b000, m_en, m_abt, m_err, !m_idle(), 9'(m_beats.size())};
   endfunction

   task automatic model_reset();
      m_beats.delete();
      m_done = 0; m_errp = 0; m_en = 0; m_err = 0; m_abt = 0; m_wr = 0;
      m_cnt  = '0;
   endtask

   // one clock: compare outputs mid-cycle, then advance the model at the edge
   task automatic cycle();
      bit idle, cfire, legal, bfire, abort, was_done, clr;
      @(negedge clk);
      chk("cmd_ready", 32'(cmd_ready), 32'(m_idle() && m_en));
      chk("beat_valid", 32'(beat_valid), 32'(m_beats.size() != 0));
      if (m_beats.size() != 0) begin
         chk("beat_addr", 32'(beat_addr), 32'(m_beats[0]));
         chk("beat_last", 32'(beat_last), 32'(m_beats.size() == 1));
         chk("beat_write", 32'(beat_write), 32'(m_wr));
      end
      chk("done", 32'(done), 32'(m_done));
      chk("error", 32'(error), 32'(m_errp));
      chk("status", status, m_status());
      @(posedge clk);
      if (rst) model_reset();
      else begin
         idle     = m_idle();
         cfire    = idle && m_en && cmd_valid;
         legal    = (cmd_len >= 1) && (cmd_len <= 256);
         bfire    = (m_beats.size() != 0) && beat_ready;
         abort    = cfg_we && cfg_wdata[1] && (m_beats.size() != 0);
         was_done = m_done;
         m_done   = bfire && (m_beats.size() == 1) && !abort;
         if (bfire) void'(m_beats.pop_front());
         if (abort) m_beats.delete();
         if (cfire && legal) begin
            for (int i = 0; i < int'(cmd_len); i++) m_beats.push_back(cmd_addr + 16'(i));
            m_wr = cmd_write;
         end
         m_errp = cfire && !legal;
         if (was_done) m_cnt = m_cnt + 16'd1;
         clr   = cfg_we && cfg_wdata[2];
         m_err = m_errp || (m_err && !clr);
         m_abt = abort || (m_abt && !clr);
         if (cfg_we) m_en = cfg_wdata[0];
      end
      #1;
   endtask

   task automatic cfg(input logic [31:0] v);
      cfg_we = 1'b1; cfg_wdata = v;
      cycle();
      cfg_we = 1'b0;
   endtask

   task automatic send_cmd(input logic [15:0] a, input logic [8:0] l, input logic w);
      bit acc, got;
      got = 0;
      cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; cmd_write = w;
      for (int i = 0; i < 100; i++) begin
         acc = m_idle() && m_en;
         beat_ready = 1'($urandom);
         cycle();
         if (acc) begin got = 1; break; end
      end
      cmd_valid = 1'b0;
      if (!got) chk("cmd_accept_timeout", 0, 1);
   endtask

   task automatic drain(input int max, input bit rnd, input bit cfgrnd);
      for (int i = 0; i < max; i++) begin
         if (m_idle()) break;
         beat_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (cfgrnd && ($urandom_range(0, 19) == 0)) begin
            cfg_we    = 1'b1;
            cfg_wdata = {29'd0, 1'($urandom), 1'($urandom), 1'b1};
            if (cfg_wdata[1]) beat_ready = 1'b0;
         end
         cycle();
         cfg_we = 1'b0;
      end
      if (!m_idle()) chk("drain_timeout", 0, 1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      model_reset();
      chk("rst_cmd_ready", 32'(cmd_ready), 0);
      chk("rst_beat_valid", 32'(beat_valid), 0);
      chk("rst_beat_addr", 32'(beat_addr), 0);
      chk("rst_beat_write", 32'(beat_write), 0);
      chk("rst_beat_last", 32'(beat_last), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_error", 32'(error), 0);
      chk("rst_status", status, 0);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 0; cmd_addr = 0; cmd_len = 0; cmd_write = 0;
      beat_ready = 0; cfg_we = 0; cfg_wdata = 0;
      repeat (3) @(posedge clk);
      do_reset();

      // basic write burst, beat_ready held high
      cfg(32'h1);
      send_cmd(16'h0100, 9'd4, 1'b1);
      drain(50, 0, 0);
      chk("count_after_first", 32'(status[31:16]), 1);

      // maximum length burst wrapping the address space with stalls
      send_cmd(16'hFFFE, 9'd256, 1'b0);
      drain(2000, 1, 0);
      chk("count_after_long", 32'(status[31:16]), 2);

      // illegal lengths then sticky clear keeping enable
      send_cmd(16'h0000, 9'd0, 1'b1);
      send_cmd(16'h0000, 9'd257, 1'b0);
      cycle();
      chk("err_sticky_set", 32'(status[10]), 1);
      cfg(32'h5);
      chk("err_sticky_clr", 32'(status[10]), 0);
      chk("enable_kept", 32'(status[12]), 1);

      // abort after 3 of 8 beats
      send_cmd(16'h2000, 9'd8, 1'b1);
      beat_ready = 1'b1;
      repeat (3) cycle();
      beat_ready = 1'b0;
      cfg(32'h3);
      chk("abort_valid_low", 32'(beat_valid), 0);
      chk("abort_sticky", 32'(status[11]), 1);
      chk("abort_count", 32'(status[31:16]), 2);
      send_cmd(16'h3000, 9'd2, 1'b0);
      drain(50, 1, 0);
      chk("count_after_abort", 32'(status[31:16]), 3);

      // disabled block ignores commands
      cfg(32'h0);
      cmd_valid = 1'b1; cmd_addr = 16'h5555; cmd_len = 9'd4;
      repeat (5) cycle();
      chk("disabled_ready", 32'(cmd_ready), 0);
      chk("disabled_valid", 32'(beat_valid), 0);
      cmd_valid = 1'b0;

      // reset mid-burst
      cfg(32'h1);
      send_cmd(16'h4000, 9'd10, 1'b1);
      beat_ready = 1'b1;
      repeat (2) cycle();
      cmd_valid = 1'b1;
      do_reset();
      cmd_valid = 1'b0;
      repeat (2) cycle();

      // randomized traffic with occasional config writes and aborts
      cfg(32'h1);
      for (int n = 0; n < 150; n++) begin
         logic [8:0] l;
         l = ($urandom_range(0, 4) == 0) ? 9'($urandom_range(0, 300)) : 9'($urandom_range(1, 12));
         send_cmd(16'($urandom), l, 1'($urandom));
         drain(1000, 1, 1);
         if (!m_en) cfg(32'h1);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
